// File: rtl/ysyx_040750_div_ctrl.sv
// EX-stage front end for the radix-2 divider: operand prep, zero/overflow short-cut,
// issue, result capture and hold. Optional one-entry cache: YSYX_040750_DIV_CACHE_EN.
//
// state | meaning
// IDLE  | ready to accept a new op
// BUSY  | divider running, result wanted
// DRAIN | flushed while divider running; wait out its Q_valid
// DONE  | result held on out_valid until out_ready or flush
module ysyx_040750_div_ctrl #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            div_valid,
   output logic            div_signed,
   output logic [XLEN-1:0] div_a,
   output logic [XLEN-1:0] div_b,
   input  logic [XLEN-1:0] div_q,
   input  logic [XLEN-1:0] div_r,
   input  logic            div_qv
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            rem_q, rem_d;
   logic            word_q, word_d;

   logic            sgn, is_zero, is_ovf, fast, accept, cache_hit, unused_f3;
   logic [XLEN-1:0] a_prep, b_prep, min_neg, fast_q, fast_r, hit_q, hit_r;

   function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   assign unused_f3 = funct3[2];
   assign sgn       = ~funct3[0];

   always_comb begin
      a_prep = src1;
      b_prep = src2;
      if (is_word) begin
         a_prep = {{(XLEN-32){sgn & src1[31]}}, src1[31:0]};
         b_prep = {{(XLEN-32){sgn & src2[31]}}, src2[31:0]};
      end
   end

   // Most-negative value of the active width, as seen after sign extension.
   assign min_neg = is_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
   assign is_zero = (b_prep == '0);
   assign is_ovf  = sgn & (a_prep == min_neg) & (b_prep == '1);
   assign fast    = is_zero | is_ovf | cache_hit;
   assign fast_q  = is_zero ? '1 : (is_ovf ? a_prep : hit_q);
   assign fast_r  = is_zero ? a_prep : (is_ovf ? '0 : hit_r);

   assign in_ready   = (state_q == S_IDLE);
   assign accept     = in_ready & in_valid & ~flush;
   assign div_valid  = accept & ~fast;
   assign div_signed = sgn;
   assign div_a      = a_prep;
   assign div_b      = b_prep;
   assign out_valid  = (state_q == S_DONE);
   assign result     = result_q;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rem_d    = rem_q;
      word_d   = word_q;
      case (state_q)
         S_IDLE: if (accept) begin
            if (fast) begin
               result_d = fin(funct3[1] ? fast_r : fast_q, is_word);
               state_d  = S_DONE;
            end else begin
               rem_d   = funct3[1];
               word_d  = is_word;
               state_d = S_BUSY;
            end
         end
         S_BUSY: if (div_qv) begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               result_d = fin(rem_q ? div_r : div_q, word_q);
               state_d  = S_DONE;
            end
         end else if (flush) begin
            state_d = S_DRAIN;
         end
         S_DRAIN: if (div_qv) state_d = S_IDLE;
         S_DONE:  if (flush || out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         rem_q    <= 1'b0;
         word_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         word_q   <= word_d;
      end
   end

`ifdef YSYX_040750_DIV_CACHE_EN
   logic            iss_sgn_q, iss_sgn_d, c_valid_q, c_valid_d, c_sgn_q, c_sgn_d;
   logic            c_word_q, c_word_d;
   logic [XLEN-1:0] iss_a_q, iss_a_d, iss_b_q, iss_b_d;
   logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_q_q, c_q_d, c_r_q, c_r_d;

   assign cache_hit = c_valid_q & (c_sgn_q == sgn) & (c_word_q == is_word) &
                      (c_a_q == a_prep) & (c_b_q == b_prep);
   assign hit_q = c_q_q;
   assign hit_r = c_r_q;

   // Any divider completion is a valid result worth keeping, flushed or not.
   always_comb begin
      iss_sgn_d = iss_sgn_q;
      iss_a_d   = iss_a_q;
      iss_b_d   = iss_b_q;
      c_valid_d = c_valid_q;
      c_sgn_d   = c_sgn_q;
      c_word_d  = c_word_q;
      c_a_d     = c_a_q;
      c_b_d     = c_b_q;
      c_q_d     = c_q_q;
      c_r_d     = c_r_q;
      if (div_valid) begin
         iss_sgn_d = sgn;
         iss_a_d   = a_prep;
         iss_b_d   = b_prep;
      end
      if (div_qv && (state_q == S_BUSY || state_q == S_DRAIN)) begin
         c_valid_d = 1'b1;
         c_sgn_d   = iss_sgn_q;
         c_word_d  = word_q;
         c_a_d     = iss_a_q;
         c_b_d     = iss_b_q;
         c_q_d     = div_q;
         c_r_d     = div_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iss_sgn_q <= 1'b0;
         iss_a_q   <= '0;
         iss_b_q   <= '0;
         c_valid_q <= 1'b0;
         c_sgn_q   <= 1'b0;
         c_word_q  <= 1'b0;
         c_a_q     <= '0;
         c_b_q     <= '0;
         c_q_q     <= '0;
         c_r_q     <= '0;
      end else begin
         iss_sgn_q <= iss_sgn_d;
         iss_a_q   <= iss_a_d;
         iss_b_q   <= iss_b_d;
         c_valid_q <= c_valid_d;
         c_sgn_q   <= c_sgn_d;
         c_word_q  <= c_word_d;
         c_a_q     <= c_a_d;
         c_b_q     <= c_b_d;
         c_q_q     <= c_q_d;
         c_r_q     <= c_r_d;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign hit_q     = '0;
   assign hit_r     = '0;
`endif

endmodule

// File: tb/tb_ysyx_040750_div_ctrl.sv
// Self-checking bench for ysyx_040750_div_ctrl with a behavioural divider model.
// Honours YSYX_040750_DIV_CACHE_EN when defined for the build.
module tb_ysyx_040750_div_ctrl;
   localparam int DIV_LAT = 65;
   localparam int NORM_LAT = 67;
   localparam bit CACHE_ON =
`ifdef YSYX_040750_DIV_CACHE_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, is_word, flush, out_valid, out_ready;
   logic [2:0]  funct3;
   logic [63:0] src1, src2, result, div_a, div_b, div_q, div_r;
   logic        div_valid, div_signed, div_qv;

   ysyx_040750_div_ctrl #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .is_word(is_word), .src1(src1), .src2(src2),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .div_valid(div_valid), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r), .div_qv(div_qv)
   );

   always #5 clk = ~clk;

   // Divider model: Q_valid pulse DIV_LAT+1 cycles after the div_valid cycle.
   int          cnt, dv_count, bad_dv;
   logic [63:0] m_q, m_r;
   always @(posedge clk) begin
      if (rst) begin
         cnt <= 0; div_qv <= 1'b0; dv_count <= 0;
      end else begin
         div_qv <= (cnt == 1);
         if (div_valid) begin
            cnt      <= DIV_LAT;
            dv_count <= dv_count + 1;
            if (!in_ready || flush) bad_dv <= bad_dv + 1;
            if (div_b == 64'd0) begin
               m_q <= '1; m_r <= div_a;
            end else if (div_signed && div_b == '1) begin
               m_q <= -div_a; m_r <= 64'd0;
            end else if (div_signed) begin
               m_q <= $signed(div_a) / $signed(div_b);
               m_r <= $signed(div_a) % $signed(div_b);
            end else begin
               m_q <= div_a / div_b;
               m_r <= div_a % div_b;
            end
         end else if (cnt != 0) begin
            cnt <= cnt - 1;
         end
      end
   end
   assign div_q = div_qv ? m_q : 64'hDEAD_BEEF_DEAD_BEEF;
   assign div_r = div_qv ? m_r : 64'hBAAD_F00D_BAAD_F00D;

   typedef struct {
      logic [2:0]  f3;
      logic        w;
      logic [63:0] s1;
      logic [63:0] s2;
      logic [63:0] exp;
      logic        fast;
      logic        hit;
   } vec_t;

   vec_t        vecs[14];
   logic [63:0] sb[$];
   int          n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] s1,
                        input logic [63:0] s2, input logic exp_fast);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      funct3 = f3; is_word = w; src1 = s1; src2 = s2; in_valid = 1'b1;
      #1 chk("div_valid_at_accept", {63'd0, div_valid}, {63'd0, !exp_fast});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      #1;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_vec(input logic [2:0] f3, input logic w, input logic [63:0] s1,
                          input logic [63:0] s2, input logic [63:0] exp, input logic fast);
      int lat, dv0;
      dv0 = dv_count;
      issue(f3, w, s1, s2, fast);
      sb.push_back(exp);
      wait_out(lat);
      chk("latency", lat, fast ? 64'd1 : NORM_LAT);
      chk("div_pulses", dv_count - dv0, fast ? 64'd0 : 64'd1);
      out_ready = 1'b1;
      if (out_valid && sb.size() > 0) chk("result", result, sb.pop_front());
      @(negedge clk);
      out_ready = 1'b0;
      #1 chk("out_valid_after_accept", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, lat, n;
      vecs[0]  = '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0};
      vecs[1]  = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 1'b1};
      vecs[2]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
      vecs[3]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
      vecs[4]  = '{3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[5]  = '{3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, 1'b0};
      vecs[6]  = '{3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
      vecs[7]  = '{3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0};
      vecs[8]  = '{3'b101, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'hABCD_0000_0000_0003, 64'd5, 1'b0, 1'b0};
      vecs[9]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
      vecs[10] = '{3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[11] = '{3'b101, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b0, 1'b0};
      vecs[12] = '{3'b111, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1};
      vecs[13] = '{3'b101, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

      bad_dv = 0;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      funct3 = 3'b101; is_word = 1'b0; src1 = 64'd0; src2 = 64'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_result", result, 64'd0);
      chk("reset_div_valid", {63'd0, div_valid}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1 chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

      // Flush in IDLE blocks accept.
      @(negedge clk);
      funct3 = 3'b101; src1 = 64'd9; src2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
      #1 chk("idle_flush_div_valid", {63'd0, div_valid}, 64'd0);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      #1 chk("idle_flush_in_ready", {63'd0, in_ready}, 64'd1);

      // Reset mid-operation.
      issue(3'b101, 1'b0, 64'd9, 64'd3, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_out_valid", seen, 64'd0);

      for (int i = 0; i < 14; i++)
         run_vec(vecs[i].f3, vecs[i].w, vecs[i].s1, vecs[i].s2, vecs[i].exp,
                 vecs[i].fast | (CACHE_ON & vecs[i].hit));

      // Flush while BUSY -> DRAIN until Q_valid, no out_valid.
      issue(3'b101, 1'b0, 64'd1000, 64'd3, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      n = 0; seen = 0;
      while (!div_qv && n < 200) begin
         if (in_ready || out_valid) seen++;
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_qv_seen", {63'd0, div_qv}, 64'd1);
      chk("drain_in_ready_out_valid", seen, 64'd0);
      chk("drain_last_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      #1;
      chk("drain_exit_in_ready", {63'd0, in_ready}, 64'd1);
      chk("drain_exit_out_valid", {63'd0, out_valid}, 64'd0);
      run_vec(3'b101, 1'b0, 64'd9, 64'd3, 64'd3, 1'b0);

      // Flush coinciding with Q_valid in BUSY discards the result.
      issue(3'b101, 1'b0, 64'd50, 64'd5, 1'b0);
      n = 0;
      #1;
      while (!div_qv && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("busyflush_qv_seen", {63'd0, div_qv}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      repeat (3) begin
         #1;
         if (out_valid || !in_ready) seen++;
         @(negedge clk);
      end
      chk("busyflush_dropped", seen, 64'd0);

      // DONE held with out_ready low, then dropped by flush.
      issue(3'b101, 1'b0, 64'd77, 64'd7, 1'b0);
      sb.push_back(64'd11);
      wait_out(lat);
      chk("hold_latency", lat, NORM_LAT);
      funct3 = 3'b101; src1 = 64'd77; src2 = 64'd7; in_valid = 1'b1;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (!out_valid || in_ready || div_valid || result !== sb[0]) seen++;
      end
      chk("hold_stable", seen, 64'd0);
      chk("hold_result", result, sb.pop_front());
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("done_flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("done_flush_in_ready", {63'd0, in_ready}, 64'd1);

      // Cache scenario: first op runs the divider, second may hit.
      run_vec(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0);
      run_vec(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, CACHE_ON);

      chk("div_valid_protocol", bad_dv, 64'd0);
      chk("scoreboard_empty", sb.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
